dmem_arbiter: RTL and testbench

DMEM_ARBITER -- requirements
Module: dmem_arbiter

---
 rtl/dmem_arbiter.sv | 160 ++++++++++++++++
 tb/tb_dmem_arbiter.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port (pipeline core + DMA) arbiter in front of a single-ported data memory.
// Round-robin arbitration with a bounded DMA burst lock and a one-cycle load return path.

module dmem_arbiter_rsp (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] rd_data,
    output logic        rvalid,
    output logic [31:0] rdata
);
    // Stores leave rdata untouched; only a granted load refreshes it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rvalid <= 1'b0;
            rdata  <= '0;
        end else begin
            rvalid <= load;
            if (load) rdata <= rd_data;
        end
    end
endmodule

module dmem_arbiter #(
    parameter int DEPTH    = 64,
    parameter int MAX_LOCK = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req,
    input  logic        core_we,
    input  logic [31:0] core_addr,
    input  logic [31:0] core_wdata,
    output logic        core_gnt,
    output logic [31:0] core_rdata,
    output logic        core_rvalid,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    input  logic        dma_lock,
    output logic        dma_gnt,
    output logic [31:0] dma_rdata,
    output logic        dma_rvalid,
    output logic        MemRW,
    output logic [31:0] read_address,
    output logic [31:0] Write_data,
    input  logic [31:0] MemData_out,
    output logic        addr_err
);
    localparam int NUM_PORTS = 2;
    localparam int CNT_W     = $clog2(MAX_LOCK + 1);

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } port_req_t;

    typedef enum logic {ARB, LOCK} state_t;

    state_t                   state;
    logic                     prio_dma;
    logic [CNT_W-1:0]         lock_cnt;
    logic [CNT_W-1:0]         lock_nxt;
    logic [NUM_PORTS-1:0]     gnt;
    logic [NUM_PORTS-1:0]     load_v;
    logic [NUM_PORTS-1:0]     rvalid_v;
    logic [NUM_PORTS-1:0][31:0] rdata_v;
    port_req_t [NUM_PORTS-1:0] preq;
    port_req_t                sel;
    logic                     gnt_any;
    logic                     in_range;
    logic                     hit;
    logic                     wr;
    logic [31:0]              rd_data;

    assign preq[0] = {core_we, core_addr, core_wdata};
    assign preq[1] = {dma_we, dma_addr, dma_wdata};

    // Grants are gated by rst_n so nothing is granted while reset is held, clock or not.
    always_comb begin
        gnt = '0;
        if (rst_n) begin
            if (state == LOCK)
                gnt[1] = dma_req;
            else if (core_req && dma_req)
                gnt = prio_dma ? 2'b10 : 2'b01;
            else
                gnt = {dma_req, core_req};
        end
    end

    assign gnt_any  = |gnt;
    assign sel      = preq[gnt[1]];
    assign in_range = sel.addr < 32'(DEPTH);
    assign hit      = gnt_any && in_range;
    assign wr       = hit && sel.we;
    assign rd_data  = in_range ? MemData_out : '0;

    assign MemRW        = ~wr;
    assign read_address = hit ? sel.addr : '0;
    assign Write_data   = wr ? sel.wdata : '0;

    assign core_gnt = gnt[0];
    assign dma_gnt  = gnt[1];
    assign load_v   = gnt & ~{dma_we, core_we};
    assign lock_nxt = lock_cnt + 1'b1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ARB;
            lock_cnt <= '0;
            prio_dma <= 1'b0;
            addr_err <= 1'b0;
        end else begin
            addr_err <= gnt_any && !in_range;
            case (state)
                ARB: begin
                    if (gnt[0])      prio_dma <= 1'b1;
                    else if (gnt[1]) prio_dma <= 1'b0;
                    // A limit of one grant means the ARB grant already exhausts the burst.
                    if (gnt[1] && dma_lock && MAX_LOCK > 1) begin
                        state    <= LOCK;
                        lock_cnt <= CNT_W'(1);
                    end
                end
                LOCK: begin
                    if (!gnt[1] || !dma_lock || lock_nxt >= CNT_W'(MAX_LOCK)) begin
                        state    <= ARB;
                        lock_cnt <= '0;
                        prio_dma <= 1'b0;
                    end else begin
                        lock_cnt <= lock_nxt;
                    end
                end
                default: begin
                    state    <= ARB;
                    lock_cnt <= '0;
                end
            endcase
        end
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rsp
        dmem_arbiter_rsp u_rsp (
            .clk    (clk),
            .rst_n  (rst_n),
            .load   (load_v[p]),
            .rd_data(rd_data),
            .rvalid (rvalid_v[p]),
            .rdata  (rdata_v[p])
        );
    end

    assign core_rvalid = rvalid_v[0];
    assign core_rdata  = rdata_v[0];
    assign dma_rvalid  = rvalid_v[1];
    assign dma_rdata   = rdata_v[1];
endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: vector table for single-cycle behaviour plus
// hand sequences for lock bursts and mid-burst reset, against a 64-word memory model.

module tb_dmem_arbiter;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we, core_gnt, core_rvalid;
    logic [31:0] core_addr, core_wdata, core_rdata;
    logic        dma_req, dma_we, dma_lock, dma_gnt, dma_rvalid;
    logic [31:0] dma_addr, dma_wdata, dma_rdata;
    logic        MemRW, addr_err;
    logic [31:0] read_address, Write_data, MemData_out;

    int tests = 0;
    int fails = 0;

    logic [31:0] mem [64] = '{default: 32'h0};

    always #5 clk = ~clk;

    assign MemData_out = mem[read_address[5:0]];
    always @(posedge clk) if (!MemRW) mem[read_address[5:0]] <= Write_data;

    dmem_arbiter #(.DEPTH(64), .MAX_LOCK(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rdata(core_rdata), .core_rvalid(core_rvalid),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
        .dma_lock(dma_lock), .dma_gnt(dma_gnt), .dma_rdata(dma_rdata), .dma_rvalid(dma_rvalid),
        .MemRW(MemRW), .read_address(read_address), .Write_data(Write_data),
        .MemData_out(MemData_out), .addr_err(addr_err)
    );

    typedef struct {
        logic        cr, cw;
        logic [31:0] ca, cd;
        logic        dr, dw;
        logic [31:0] da, dd;
        logic        dl;
        logic        ecg, edg, emrw;
        logic [31:0] era, ewd;
        logic        ecrv;
        logic [31:0] ecrd;
        logic        edrv;
        logic [31:0] edrd;
        logic        eaerr;
    } vec_t;

    vec_t vecs [13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic cr, input logic cw, input logic [31:0] ca, input logic [31:0] cd,
                         input logic dr, input logic dw, input logic [31:0] da, input logic [31:0] dd,
                         input logic dl);
        core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
        dma_req = dr; dma_we = dw; dma_addr = da; dma_wdata = dd; dma_lock = dl;
    endtask

    task automatic idle();
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Pattern used by the lock burst: dma x4, core, dma.
    logic [5:0] burst_dma;

    initial begin
        //           cr cw ca  cd            dr dw da   dd            dl  ecg edg mrw era ewd           crv crd           drv drd           aerr
        vecs[0]  = '{1, 0, 3,  0,            0, 0, 0,   0,            0,  1,  0,  1,  3,  0,            1,  0,            0,  0,            0};
        vecs[1]  = '{1, 1, 5,  32'hDEADBEEF, 0, 0, 0,   0,            0,  1,  0,  0,  5,  32'hDEADBEEF, 0,  0,            0,  0,            0};
        vecs[2]  = '{1, 0, 5,  0,            0, 0, 0,   0,            0,  1,  0,  1,  5,  0,            1,  32'hDEADBEEF, 0,  0,            0};
        vecs[3]  = '{1, 0, 5,  0,            1, 0, 5,   0,            0,  0,  1,  1,  5,  0,            0,  32'hDEADBEEF, 1,  32'hDEADBEEF, 0};
        vecs[4]  = '{1, 0, 5,  0,            1, 0, 5,   0,            0,  1,  0,  1,  5,  0,            1,  32'hDEADBEEF, 0,  32'hDEADBEEF, 0};
        vecs[5]  = '{1, 0, 10, 0,            1, 0, 7,   0,            0,  0,  1,  1,  7,  0,            0,  32'hDEADBEEF, 1,  0,            0};
        vecs[6]  = '{1, 0, 10, 0,            1, 0, 7,   0,            0,  1,  0,  1,  10, 0,            1,  0,            0,  0,            0};
        vecs[7]  = '{0, 0, 0,  0,            1, 1, 70,  32'h12345678, 0,  0,  1,  1,  0,  0,            0,  0,            0,  0,            1};
        vecs[8]  = '{1, 0, 6,  0,            0, 0, 0,   0,            0,  1,  0,  1,  6,  0,            1,  0,            0,  0,            0};
        vecs[9]  = '{0, 0, 0,  0,            1, 0, 100, 0,            0,  0,  1,  1,  0,  0,            0,  0,            1,  0,            1};
        vecs[10] = '{0, 0, 0,  0,            0, 0, 0,   0,            0,  0,  0,  1,  0,  0,            0,  0,            0,  0,            0};
        vecs[11] = '{0, 0, 0,  0,            1, 1, 10,  32'hA5A50001, 0,  0,  1,  0,  10, 32'hA5A50001, 0,  0,            0,  0,            0};
        vecs[12] = '{1, 0, 10, 0,            0, 0, 0,   0,            0,  1,  0,  1,  10, 0,            1,  32'hA5A50001, 0,  0,            0};
        burst_dma = 6'b101111;

        // Reset held with both ports requesting.
        rst_n = 1'b0;
        drive(1, 1, 5, 32'h11111111, 1, 1, 6, 32'h22222222, 1);
        #12;
        check("rst_core_gnt", 32'(core_gnt), 0);
        check("rst_dma_gnt", 32'(dma_gnt), 0);
        check("rst_memrw", 32'(MemRW), 1);
        check("rst_rvalids", {30'b0, core_rvalid, dma_rvalid}, 0);
        check("rst_rdata", core_rdata | dma_rdata, 0);
        check("rst_addr_err", 32'(addr_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();

        for (int i = 0; i < 13; i++) begin
            @(negedge clk);
            drive(vecs[i].cr, vecs[i].cw, vecs[i].ca, vecs[i].cd,
                  vecs[i].dr, vecs[i].dw, vecs[i].da, vecs[i].dd, vecs[i].dl);
            #1;
            check($sformatf("v%0d_core_gnt", i), 32'(core_gnt), 32'(vecs[i].ecg));
            check($sformatf("v%0d_dma_gnt", i), 32'(dma_gnt), 32'(vecs[i].edg));
            check($sformatf("v%0d_both_gnt", i), 32'(core_gnt & dma_gnt), 0);
            check($sformatf("v%0d_memrw", i), 32'(MemRW), 32'(vecs[i].emrw));
            check($sformatf("v%0d_read_address", i), read_address, vecs[i].era);
            check($sformatf("v%0d_write_data", i), Write_data, vecs[i].ewd);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_core_rvalid", i), 32'(core_rvalid), 32'(vecs[i].ecrv));
            check($sformatf("v%0d_core_rdata", i), core_rdata, vecs[i].ecrd);
            check($sformatf("v%0d_dma_rvalid", i), 32'(dma_rvalid), 32'(vecs[i].edrv));
            check($sformatf("v%0d_dma_rdata", i), dma_rdata, vecs[i].edrd);
            check($sformatf("v%0d_addr_err", i), 32'(addr_err), 32'(vecs[i].eaerr));
        end
        check("mem70_alias_untouched", mem[6], 0);

        // Locked DMA burst against a continuously requesting core (pointer favours DMA here).
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) drive(1, 0, 3, 0, 1, 0, 5, 0, 1);
            #1;
            check($sformatf("lock%0d_dma_gnt", i), 32'(dma_gnt), 32'(burst_dma[i]));
            check($sformatf("lock%0d_core_gnt", i), 32'(core_gnt), 32'(!burst_dma[i]));
        end
        // Still in LOCK after the sixth grant; DMA drops so nobody is granted this cycle.
        @(negedge clk);
        drive(1, 0, 3, 0, 0, 0, 0, 0, 0);
        #1;
        check("lock_exit_no_gnt", {30'b0, core_gnt, dma_gnt}, 0);
        @(negedge clk);
        idle();

        // Reset during lock cycle 2.
        @(negedge clk);
        drive(0, 0, 0, 0, 1, 0, 5, 0, 1);
        #1;
        check("rlock1_dma_gnt", 32'(dma_gnt), 1);
        @(negedge clk);
        core_req = 1'b1;
        #1;
        check("rlock2_dma_gnt", 32'(dma_gnt), 1);
        check("rlock2_dma_rvalid", 32'(dma_rvalid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("rlock_rst_gnts", {30'b0, core_gnt, dma_gnt}, 0);
        check("rlock_rst_memrw", 32'(MemRW), 1);
        check("rlock_rst_rvalids", {30'b0, core_rvalid, dma_rvalid}, 0);
        check("rlock_rst_rdata", core_rdata | dma_rdata, 0);
        check("rlock_rst_addr_err", 32'(addr_err), 0);
        @(posedge clk);
        #1;
        check("rlock_rst_clk_gnts", {30'b0, core_gnt, dma_gnt}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("post_rst_core_gnt", 32'(core_gnt), 1);
        check("post_rst_dma_gnt", 32'(dma_gnt), 0);
        @(negedge clk);
        #1;
        check("post_rst2_dma_gnt", 32'(dma_gnt), 1);
        check("post_rst2_core_gnt", 32'(core_gnt), 0);
        @(negedge clk);
        idle();
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
